imem_fetch_ctrl: RTL and testbench

Fetch sequencer for the sequential RISC-V core. It owns the program counter and drives the synchronous instruction memory address. It tracks the one read in flight and hands each fetched instruction, with its PC, to decode over a valid/ready handshake. It also handles branch/jump redirects, stalls and misaligned-target faults, and sits between the instruction memory and the decode stage.

---
 rtl/imem_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, tracks one instruction-memory read in flight and
// hands instructions to decode. Optional perf counters: IMEM_FETCH_CTRL_PERF_EN.
module imem_fetch_ctrl #(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               fault
`ifdef IMEM_FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(3'd4);

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 run_s;
    logic                 misaligned_s;
    logic                 issue_s;
    logic                 slot_free_s;

    logic [PC_W-1:0]      pc_r;
    logic                 inflight_r;
    logic [PC_W-1:0]      inflight_pc_r;
    logic                 skid_valid_r;
    logic [PC_W-1:0]      skid_pc_r;
    logic [INSTR_W-1:0]   skid_instr_r;

    assign imem_pc      = pc_r;
    assign misaligned_s = (redirect_pc[1:0] != 2'b00);
    assign slot_free_s  = !out_valid || out_ready;
    // Hold off issue while a return would have nowhere to land.
    assign issue_s      = run_s && fetch_en && !redirect_valid && !skid_valid_r &&
                          !(inflight_r && out_valid && !out_ready);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: only a redirect moves between RUN and FAULT.
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_valid) begin
            if (misaligned_s) begin
                state_nxt_s = ST_FAULT;
            end else begin
                state_nxt_s = ST_RUN;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State decode outputs.
    always_comb begin
        run_s = 1'b0;
        fault = 1'b0;
        case (state_r)
            ST_RUN:   run_s = 1'b1;
            ST_FAULT: fault = 1'b1;
            default: begin
                run_s = 1'b0;
                fault = 1'b1;
            end
        endcase
    end

    // PC, in-flight tracking, output slot and skid buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {PC_W{1'b0}};
            out_valid     <= 1'b0;
            out_pc        <= {PC_W{1'b0}};
            out_instr     <= {INSTR_W{1'b0}};
            skid_valid_r  <= 1'b0;
            skid_pc_r     <= {PC_W{1'b0}};
            skid_instr_r  <= {INSTR_W{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
                pc_r          <= pc_r + PC_STEP;
            end
            if (redirect_valid) begin
                // Flush everything from the old stream, including this cycle's return.
                pc_r         <= redirect_pc;
                out_valid    <= 1'b0;
                skid_valid_r <= 1'b0;
            end else if (slot_free_s) begin
                if (skid_valid_r) begin
                    out_valid    <= 1'b1;
                    out_pc       <= skid_pc_r;
                    out_instr    <= skid_instr_r;
                    skid_valid_r <= inflight_r;
                    skid_pc_r    <= inflight_pc_r;
                    skid_instr_r <= imem_instr;
                end else if (inflight_r) begin
                    out_valid <= 1'b1;
                    out_pc    <= inflight_pc_r;
                    out_instr <= imem_instr;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (inflight_r) begin
                skid_valid_r <= 1'b1;
                skid_pc_r    <= inflight_pc_r;
                skid_instr_r <= imem_instr;
            end
        end
    end

`ifdef IMEM_FETCH_CTRL_PERF_EN
    // Accepted-instruction and back-pressure counters, free-running modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (out_valid && out_ready) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: stream-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b1;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;
`ifdef IMEM_FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    int          m_fetched = 0;
    int          m_stall = 0;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    imem_fetch_ctrl dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_pc(imem_pc),
        .imem_instr(imem_instr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .fault(fault)
`ifdef IMEM_FETCH_CTRL_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0003;
    endfunction

    // Synchronous instruction memory: data for the presented address one cycle later.
    always @(posedge clk) imem_instr <= instr_of(imem_pc);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: program-order stream, hold-under-backpressure, flush and fault.
    logic [63:0] exp_pc = 64'd0;
    logic        mfault = 1'b0;
    logic        prev_ok = 1'b0;
    logic        p_rv, p_ov, p_or;
    logic [63:0] p_rpc, p_pc, p_opc;

    always @(negedge clk) begin
        if (reset) begin
            exp_pc  = 64'd0;
            mfault  = 1'b0;
            prev_ok = 1'b0;
`ifdef IMEM_FETCH_CTRL_PERF_EN
            m_fetched = 0;
            m_stall   = 0;
`endif
        end else begin
            if (prev_ok) begin
                if (p_rv) begin
                    chk("m_redirect_flush", {63'd0, out_valid}, 64'd0);
                    chk("m_redirect_pc", imem_pc, p_rpc);
                    mfault = (p_rpc[1:0] != 2'b00);
                end else begin
                    if (p_ov && !p_or) begin
                        chk("m_hold_valid", {63'd0, out_valid}, 64'd1);
                        chk("m_hold_pc", out_pc, p_opc);
                    end
                    chk("m_pc_step", {63'd0, (imem_pc == p_pc) || (imem_pc == p_pc + 64'd4)}, 64'd1);
                end
            end
            chk("m_fault", {63'd0, fault}, {63'd0, mfault});
            if (mfault) chk("m_fault_quiet", {63'd0, out_valid}, 64'd0);
            if (out_valid) begin
                chk("m_order_pc", out_pc, exp_pc);
                chk("m_instr", {32'd0, out_instr}, {32'd0, instr_of(out_pc)});
                if (out_ready) exp_pc = exp_pc + 64'd4;
            end
`ifdef IMEM_FETCH_CTRL_PERF_EN
            if (out_valid && out_ready) m_fetched++;
            if (out_valid && !out_ready) m_stall++;
`endif
            if (redirect_valid) exp_pc = redirect_pc;
            p_rv = redirect_valid; p_rpc = redirect_pc; p_ov = out_valid;
            p_or = out_ready; p_pc = imem_pc; p_opc = out_pc;
            prev_ok = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] rdy_pat;
        rdy_pat = 24'b1101_0011_1110_0101_1011_0111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_pc", imem_pc, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        reset = 1'b0;

        // Streaming from reset.
        step();
        chk("s1_imem_pc", imem_pc, 64'd4);
        chk("s1_valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("s2_valid", {63'd0, out_valid}, 64'd1);
        chk("s2_out_pc", out_pc, 64'd0);
        chk("s2_instr", {32'd0, out_instr}, 64'hDEAD_0003);
        chk("s2_imem_pc", imem_pc, 64'd8);
        step();
        chk("s3_out_pc", out_pc, 64'd4);
        chk("s3_instr", {32'd0, out_instr}, 64'hDEAD_0007);
        chk("s3_imem_pc", imem_pc, 64'd12);

        // Back-pressure for three cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_out_pc", out_pc, 64'd4);
            chk("bp_instr", {32'd0, out_instr}, 64'hDEAD_0007);
            chk("bp_imem_pc", imem_pc, 64'd12);
        end
        out_ready = 1'b1;
        step();
        chk("rel_out_pc8", out_pc, 64'd8);
        chk("rel_instr8", {32'd0, out_instr}, 64'hDEAD_000B);
        step();
        step();
        chk("rel_out_pc12", out_pc, 64'd12);
        chk("rel_instr12", {32'd0, out_instr}, 64'hDEAD_000F);

        // Redirect with a read in flight.
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        step();
        redirect_valid = 1'b0;
        chk("rd_flush", {63'd0, out_valid}, 64'd0);
        chk("rd_imem_pc", imem_pc, 64'h100);
        step();
        chk("rd_gap", {63'd0, out_valid}, 64'd0);
        step();
        chk("rd_valid", {63'd0, out_valid}, 64'd1);
        chk("rd_out_pc", out_pc, 64'h100);
        chk("rd_instr", {32'd0, out_instr}, 64'hDEAD_0103);

        // Misaligned target, then recovery.
        redirect_valid = 1'b1; redirect_pc = 64'h102;
        step();
        redirect_valid = 1'b0;
        chk("mis_fault", {63'd0, fault}, 64'd1);
        chk("mis_valid", {63'd0, out_valid}, 64'd0);
        step();
        step();
        chk("mis_hold_pc", imem_pc, 64'h102);
        chk("mis_still_quiet", {63'd0, out_valid}, 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h200;
        step();
        redirect_valid = 1'b0;
        chk("rec_fault", {63'd0, fault}, 64'd0);
        step();
        step();
        chk("rec_out_pc", out_pc, 64'h200);
        chk("rec_instr", {32'd0, out_instr}, 64'hDEAD_0203);

        // PC wrap-around.
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_target", imem_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_imem_pc", imem_pc, 64'd0);
        step();
        chk("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_instr", {32'd0, out_instr}, 64'h2152_FFFF);

        // Fill the skid buffer, then reset asynchronously mid-cycle.
        out_ready = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_pc", out_pc, 64'd0);
        chk("arst_instr", {32'd0, out_instr}, 64'd0);
        chk("arst_imem_pc", imem_pc, 64'd0);
        chk("arst_fault", {63'd0, fault}, 64'd0);
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        chk("post_rst_out_pc", out_pc, 64'd0);

        // fetch_en low: no new reads, in-flight one still lands.
        fetch_en = 1'b0;
        step();
        chk("fe_out_pc", out_pc, 64'd4);
        step();
        chk("fe_drained", {63'd0, out_valid}, 64'd0);
        chk("fe_imem_pc", imem_pc, 64'd8);
        fetch_en = 1'b1;

        // Mixed back-pressure pattern, checked by the model.
        for (int i = 0; i < 24; i++) begin
            out_ready = rdy_pat[i];
            step();
        end
        out_ready = 1'b1;
        repeat (4) step();
`ifdef IMEM_FETCH_CTRL_PERF_EN
        chk("perf_fetched", {32'd0, perf_fetched}, 64'(m_fetched));
        chk("perf_stall", {32'd0, perf_stall}, 64'(m_stall));
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
